// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs, status encoding
// and small helpers for classifying a retiring instruction.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Register IDs
    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    // Processor status
    typedef enum logic [2:0] {
        AOK = 3'd1,
        HLT = 3'd2,
        ADR = 3'd3,
        INS = 3'd4
    } stat_t;

    // True for any icode the machine defines.
    function automatic logic icode_valid(input logic [3:0] code);
        return code <= IPOPQ;
    endfunction

    // Status an instruction leaves behind; ADR beats INS beats HLT.
    function automatic stat_t instr_outcome(input logic [3:0] code, input logic merr);
        if (merr) begin
            return ADR;
        end else if (!icode_valid(code)) begin
            return INS;
        end else if (code == IHALT) begin
            return HLT;
        end
        return AOK;
    endfunction

endpackage

// File: rtl/y86_wb_dst_dec.sv
// Writeback destination decode: maps icode/rA/rB/cnd onto the E and M
// destination register IDs. RNONE means "no write on this path".
import y86_pkg::*;

module y86_wb_dst_dec (
    input  logic [3:0] icode,
    input  logic [3:0] rA,
    input  logic [3:0] rB,
    input  logic       cnd,
    output logic [3:0] dstE,
    output logic [3:0] dstM
);

    // E destination: ALU result target, conditional for cmovXX
    always_comb begin
        dstE = RNONE;
        case (icode)
            IRRMOVQ:                   dstE = cnd ? rB : RNONE;
            IIRMOVQ, IOPQ:             dstE = rB;
            ICALL, IRET, IPUSHQ, IPOPQ: dstE = RRSP;
            default:                   dstE = RNONE;
        endcase
    end

    // M destination: memory load target
    always_comb begin
        dstM = RNONE;
        case (icode)
            IMRMOVQ, IPOPQ: dstM = rA;
            default:        dstM = RNONE;
        endcase
    end

endmodule

// File: rtl/y86_regfile_wb.sv
// Y86-64 writeback stage and architectural register file.
// Two combinational read ports, dual write (E and M) per retiring instruction,
// processor status FSM and retired-instruction counter.
// Optional macro Y86_WB_BYPASS_EN: forward same-cycle write data to the read
// ports (valM over valE over array). Undefined: writes visible next cycle.
import y86_pkg::*;

module y86_regfile_wb #(
    parameter int unsigned NREG  = 15,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_valid,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             cnd,
    input  logic [63:0]      valE,
    input  logic [63:0]      valM,
    input  logic             mem_err,
    input  logic [3:0]       srcA,
    input  logic [3:0]       srcB,
    output logic [63:0]      valA,
    output logic [63:0]      valB,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    logic [3:0]       dstE;
    logic [3:0]       dstM;
    logic [63:0]      regs_q [NREG];
    logic [63:0]      regs_d [NREG];
    stat_t            stat_q;
    stat_t            stat_d;
    stat_t            outcome;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             active;
    logic             wr_en;
    logic             retire;
    logic [63:0]      arr_a;
    logic [63:0]      arr_b;

    y86_wb_dst_dec u_dst_dec (
        .icode (icode),
        .rA    (rA),
        .rB    (rB),
        .cnd   (cnd),
        .dstE  (dstE),
        .dstM  (dstM)
    );

    // Qualify the retiring instruction against the current machine status
    always_comb begin
        outcome = instr_outcome(icode, mem_err);
        active  = wb_valid && (stat_q == AOK);
        wr_en   = active && (outcome == AOK);
        // Halt still retires; faulting instructions do not.
        retire  = active && ((outcome == AOK) || (outcome == HLT));
    end

    // ---------------------------------------------------------------------
    // Register array
    // ---------------------------------------------------------------------

    // Next-state of the array; M write overrides E write to the same ID
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && (dstM == 4'(i))) begin
                regs_d[i] = valM;
            end else if (wr_en && (dstE == 4'(i))) begin
                regs_d[i] = valE;
            end
        end
    end

    // Array state; reset loads each register with its own index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= 64'(i);
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Raw array reads; IDs with no backing register (incl. RNONE) read 0
    always_comb begin
        arr_a = '0;
        arr_b = '0;
        for (int i = 0; i < NREG; i++) begin
            if (srcA == 4'(i)) arr_a = regs_q[i];
            if (srcB == 4'(i)) arr_b = regs_q[i];
        end
    end

    // Read port data, optionally forwarding the in-flight writes
    always_comb begin
`ifdef Y86_WB_BYPASS_EN
        if (wr_en && (srcA != RNONE) && (srcA == dstM)) begin
            valA = valM;
        end else if (wr_en && (srcA != RNONE) && (srcA == dstE)) begin
            valA = valE;
        end else begin
            valA = arr_a;
        end
        if (wr_en && (srcB != RNONE) && (srcB == dstM)) begin
            valB = valM;
        end else if (wr_en && (srcB != RNONE) && (srcB == dstE)) begin
            valB = valE;
        end else begin
            valB = arr_b;
        end
`else
        valA = arr_a;
        valB = arr_b;
`endif
    end

    // ---------------------------------------------------------------------
    // Status FSM
    // ---------------------------------------------------------------------

    // Status register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= AOK;
        end else begin
            stat_q <= stat_d;
        end
    end

    // Next status: only AOK can move; every other state is terminal
    always_comb begin
        stat_d = stat_q;
        case (stat_q)
            AOK:     stat_d = active ? outcome : AOK;
            default: stat_d = stat_q;
        endcase
    end

    // Status outputs, both derived from the registered state
    always_comb begin
        stat   = stat_q;
        halted = (stat_q != AOK);
    end

    // ---------------------------------------------------------------------
    // Retired-instruction counter
    // ---------------------------------------------------------------------

    // Counter next-state; wraps naturally at 2^CNT_W
    always_comb begin
        cnt_d = cnt_q;
        if (retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign instr_count = cnt_q;

endmodule

// File: tb/tb_y86_regfile_wb.sv
// Directed bench for y86_regfile_wb: reset state, OPq, cmov, popq %rsp,
// mrmovq, pushq, halt, ADR and INS faults, asynchronous reset.
module tb_y86_regfile_wb;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        mem_err;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [2:0]  stat;
    logic        halted;
    logic [63:0] instr_count;

    int n_cmp  = 0;
    int n_fail = 0;

    y86_regfile_wb #(
        .NREG  (15),
        .CNT_W (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_valid    (wb_valid),
        .icode       (icode),
        .rA          (rA),
        .rB          (rB),
        .cnd         (cnd),
        .valE        (valE),
        .valM        (valM),
        .mem_err     (mem_err),
        .srcA        (srcA),
        .srcB        (srcB),
        .valA        (valA),
        .valB        (valB),
        .stat        (stat),
        .halted      (halted),
        .instr_count (instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction for one rising edge, then drop wb_valid.
    task automatic retire(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                          input logic c, input logic [63:0] ve, input logic [63:0] vm,
                          input logic me);
        icode    = ic;
        rA       = ra;
        rB       = rb;
        cnd      = c;
        valE     = ve;
        valM     = vm;
        mem_err  = me;
        wb_valid = 1'b1;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        mem_err  = 1'b0;
    endtask

    task automatic pulse_reset();
        wb_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
    endtask

    initial begin
        rst_n    = 1'b1;
        wb_valid = 1'b0;
        icode    = 4'h1;
        rA       = 4'hF;
        rB       = 4'hF;
        cnd      = 1'b0;
        valE     = '0;
        valM     = '0;
        mem_err  = 1'b0;
        srcA     = 4'd3;
        srcB     = 4'd14;
        #2;
        rst_n = 1'b0;
        #10;

        // Reset state
        check("rst_valA_rbx", valA, 64'h3);
        check("rst_valB_r14", valB, 64'hE);
        check("rst_stat", 64'(stat), 64'd1);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_count", instr_count, 64'd0);
        srcA = 4'hF;
        #1;
        check("rnone_reads_zero", valA, 64'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // OPq into rdx; same-cycle read depends on the forwarding build option
        srcA     = 4'd2;
        icode    = 4'h6;
        rB       = 4'd2;
        rA       = 4'hF;
        valE     = 64'h55;
        wb_valid = 1'b1;
        #1;
`ifdef Y86_WB_BYPASS_EN
        check("opq_same_cycle", valA, 64'h55);
`else
        check("opq_same_cycle", valA, 64'h2);
`endif
        retire(4'h6, 4'hF, 4'd2, 1'b0, 64'h55, 64'h0, 1'b0);
        check("opq_rdx", valA, 64'h55);
        check("opq_count", instr_count, 64'd1);

        // cmov not taken then taken
        srcA = 4'd1;
        retire(4'h2, 4'd0, 4'd1, 1'b0, 64'h77, 64'h0, 1'b0);
        check("cmov_nt_rcx", valA, 64'h1);
        retire(4'h2, 4'd0, 4'd1, 1'b1, 64'h77, 64'h0, 1'b0);
        check("cmov_t_rcx", valA, 64'h77);
        check("cmov_count", instr_count, 64'd3);

        // popq %rsp: valM must win over the rsp increment
        srcA = 4'd4;
        srcB = 4'd4;
        retire(4'hB, 4'd4, 4'hF, 1'b0, 64'h100, 64'hABC, 1'b0);
        check("popq_rsp_a", valA, 64'hABC);
        check("popq_rsp_b", valB, 64'hABC);

        // mrmovq into rdi
        srcA = 4'd7;
        retire(4'h5, 4'd7, 4'd4, 1'b0, 64'h300, 64'h42, 1'b0);
        check("mrmovq_rdi", valA, 64'h42);
        check("mrmovq_count", instr_count, 64'd5);

        // halt retires and counts
        retire(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
        check("halt_stat", 64'(stat), 64'd2);
        check("halt_halted", 64'(halted), 64'd1);
        check("halt_count", instr_count, 64'd6);

        // After halt: OPq into rbp is ignored
        srcA = 4'd5;
        retire(4'h6, 4'hF, 4'd5, 1'b0, 64'h1234, 64'h0, 1'b0);
        check("post_halt_rbp", valA, 64'h5);
        check("post_halt_count", instr_count, 64'd6);
        check("post_halt_stat", 64'(stat), 64'd2);

        // Asynchronous reset mid-run, no clock edge involved
        srcA = 4'd2;
        srcB = 4'd4;
        pulse_reset();
        check("arst_rdx", valA, 64'h2);
        check("arst_rsp", valB, 64'h4);
        check("arst_stat", 64'(stat), 64'd1);
        check("arst_halted", 64'(halted), 64'd0);
        check("arst_count", instr_count, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // pushq updates rsp from valE
        srcA = 4'd4;
        retire(4'hA, 4'd3, 4'hF, 1'b0, 64'h200, 64'h0, 1'b0);
        check("pushq_rsp", valA, 64'h200);
        check("pushq_count", instr_count, 64'd1);

        // mrmovq with address error: ADR, no write, no count
        srcA = 4'd6;
        retire(4'h5, 4'd6, 4'd4, 1'b0, 64'h999, 64'h999, 1'b1);
        check("adr_stat", 64'(stat), 64'd3);
        check("adr_halted", 64'(halted), 64'd1);
        check("adr_rsi", valA, 64'h6);
        check("adr_count", instr_count, 64'd1);

        // Invalid icode after a fresh reset: INS, no count
        pulse_reset();
        @(negedge clk);
        rst_n = 1'b1;
        retire(4'hC, 4'd1, 4'd2, 1'b1, 64'hDEAD, 64'hBEEF, 1'b0);
        check("ins_stat", 64'(stat), 64'd4);
        check("ins_count", instr_count, 64'd0);
        srcA = 4'd2;
        srcB = 4'd1;
        #1;
        check("ins_rdx", valA, 64'h2);
        check("ins_rcx", valB, 64'h1);

        // Fault beats invalid icode: mem_err with icode C gives ADR
        pulse_reset();
        @(negedge clk);
        rst_n = 1'b1;
        retire(4'hC, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b1);
        check("prio_adr_over_ins", 64'(stat), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/y86_regfile_wb.md
Name: y86_regfile_wb

Overview:
- Y86-64 sequential writeback stage plus architectural register file.
- It is the write side of the register-read path used by decode. It derives dstE/dstM from icode/rA/rB/cnd and commits valE/valM on the clock edge.
- It serves two combinational read ports (srcA/srcB) back to decode.
- It holds the processor status state machine (AOK/HLT/ADR/INS) and a retired-instruction counter.

Parameters:
- NREG, 15, number of architectural registers (IDs 0..14; ID 15 = RNONE).
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  writeback inputs valid this cycle; one instruction retires per asserted cycle.
- icode  in  4  instruction code of retiring instruction.
- rA  in  4  register field A.
- rB  in  4  register field B.
- cnd  in  1  condition result (for cmovXX).
- valE  in  64  ALU result.
- valM  in  64  memory read result.
- mem_err  in  1  memory stage address error for this instruction.
- srcA  in  4  read port A register ID.
- srcB  in  4  read port B register ID.
- valA  out  64  read data A.
- valB  out  64  read data B.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- halted  out  1  high when stat != AOK.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, rst_n=0): register i loads 64'(i) for i=0..14 (rax=0 … r14=0xE). Also stat=AOK, halted=0, instr_count=0. Reset mid-operation aborts any pending write immediately.
- dstE decode:
  - icode 2: rB if cnd=1, else 15.
  - icode 3, 6: rB.
  - icode 8, 9, A, B: 4 (%rsp).
  - all others: 15.
- dstM decode: icode 5 or B gives rA; all others 15.
- Write enable: wb_valid=1 AND stat==AOK AND the instruction's outcome is AOK (no mem_err, icode ≤ B, icode ≠ 0).
  - The dstE write and dstM write occur on the same rising edge.
  - Writes to ID 15 are ignored.
  - If dstE==dstM (popq %rsp), valM wins.
- Status FSM, evaluated on a rising edge with wb_valid=1 while in AOK:
  - mem_err=1 goes to ADR.
  - Otherwise icode > B goes to INS.
  - Otherwise icode==0 goes to HLT.
  - Otherwise stays AOK.
  - Priority is ADR > INS > HLT.
  - HLT, ADR and INS are terminal until reset. In a terminal state, wb_valid is ignored: no writes, no count.
- instr_count increments by 1 on each edge with wb_valid=1, stat==AOK and next state AOK or HLT. Halt counts; ADR and INS do not. It wraps modulo 2^CNT_W.
- Read ports are combinational from the register array. srcX==15 returns 0.
- A write is visible on valA/valB from the cycle after the committing edge (latency 1).
- Both ports may read the same register simultaneously.
- halted = (stat != AOK), registered with stat.

Optional Feature:
- Macro: Y86_WB_BYPASS_EN.
- Defined:
  - valA/valB forward same-cycle write data when srcX matches an enabled dstM or dstE (srcX≠15).
  - Priority: valM > valE > register array.
  - Forwarding uses the same enable as the write.
- Undefined: pure array read, 1-cycle visibility.

Decomposition:
- Package y86_pkg holds:
  - icode constants: IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B.
  - Register ID constants: RRSP=4, RNONE=F.
  - stat_t enum: AOK=1, HLT=2, ADR=3, INS=4.
- One sub-module, y86_wb_dst_dec: combinational icode/rA/rB/cnd → dstE/dstM.

Test Plan:
- Reset then read srcA=3, srcB=14 → valA=0x3, valB=0xE, stat=1, instr_count=0.
- OPq (icode 6, rB=2, valE=0x55, wb_valid=1) → next cycle srcA=2 reads 0x55; instr_count=1. With Y86_WB_BYPASS_EN, valA=0x55 in the same cycle.
- cmov (icode 2, rB=1, valE=0x77): with cnd=0, rcx stays 0x1. With cnd=1, rcx=0x77.
- popq %rsp (icode B, rA=4, valE=0x100, valM=0xABC) → rsp=0xABC.
- halt (icode 0) → stat=2, halted=1, instr_count+1. A following OPq writing rB=5 leaves rbp=0x5 and the count unchanged.
- mem_err=1 with mrmovq → stat=3, dstM not written, count unchanged. rst_n low mid-run restores all registers to index values and stat=1 asynchronously.
